// File: rtl/qmult_seq_if.sv
// -----------------------------------------------------------------------------
// qmult_seq_if
// Operand/result bus for the sequential sign-magnitude fixed-point multiplier.
// It uses the same start/complete handshake as the companion divider, so one
// bus can drive either engine.
//
// Signals (named from the multiplier's point of view):
//   i_multiplicand [N-1:0]  operand A, sign-magnitude Q-format
//   i_multiplier   [N-1:0]  operand B, sign-magnitude Q-format
//   i_start                 request, sampled only while o_complete=1
//   o_result_out   [N-1:0]  product, bit N-1 = sign
//   o_complete              1 = idle/result valid, 0 = busy
//   o_overflow              product magnitude exceeded N-1 bits
// Modports: slave (the multiplier), master (the requester).
// -----------------------------------------------------------------------------
interface qmult_seq_if #(
    parameter int N = 32
);
    logic [N-1:0] i_multiplicand;
    logic [N-1:0] i_multiplier;
    logic         i_start;
    logic [N-1:0] o_result_out;
    logic         o_complete;
    logic         o_overflow;

    modport slave (
        input  i_multiplicand,
        input  i_multiplier,
        input  i_start,
        output o_result_out,
        output o_complete,
        output o_overflow
    );

    modport master (
        output i_multiplicand,
        output i_multiplier,
        output i_start,
        input  o_result_out,
        input  o_complete,
        input  o_overflow
    );
endinterface

// File: rtl/qmult_seq.sv
// -----------------------------------------------------------------------------
// qmult_seq
// Sequential shift-and-add multiplier for sign-magnitude (Q,N) fixed-point
// numbers. One multiplier bit is retired per clock; latency is N-1 cycles
// from acceptance to o_complete rising.
//
// Parameters:
//   Q  fractional bits (1 <= Q <= N-2)
//   N  total width including sign bit
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      qmult_seq_if.slave (operands, start, result, complete, overflow)
// Build option:
//   QMULT_ROUND_EN  when defined, the magnitude is rounded half up
//                   (P[N-2+Q:Q] + P[Q-1]); a carry out of the magnitude sets
//                   o_overflow and the magnitude wraps. Otherwise truncation.
// -----------------------------------------------------------------------------
module qmult_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    qmult_seq_if.slave  bus
);
    localparam int PW = 2 * N - 2;      // full product width
    localparam int CW = $clog2(N);      // wide enough to hold N-2

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;          // |A|, shifted left each cycle
    logic [N-2:0]    b_q, b_d;          // |B|, shifted right each cycle
    logic [PW-1:0]   acc_q, acc_d;      // partial product sum
    logic [CW-1:0]   count_q, count_d;
    logic            sign_q, sign_d;
    logic [N-1:0]    result_q, result_d;
    logic            ovf_q, ovf_d;

    // Accumulator including the current partial product; on the last RUN
    // cycle this is the complete product P.
    logic [PW-1:0]   prod_next;
    logic [N-2:0]    mag_final;
    logic            ovf_final;

    assign prod_next = acc_q + (b_q[0] ? a_q : '0);

`ifdef QMULT_ROUND_EN
    // Shift so that bit 0 is the rounding bit P[Q-1]; the sum's top bit is
    // the carry out of the magnitude.
    logic [PW-1:0]   prod_sh;
    logic [N-1:0]    mag_sum;
    assign prod_sh   = prod_next >> (Q - 1);
    assign mag_sum   = {1'b0, prod_sh[N-1:1]} + {{(N-1){1'b0}}, prod_sh[0]};
    assign mag_final = mag_sum[N-2:0];
    assign ovf_final = (|prod_sh[PW-1:N]) | mag_sum[N-1];
`else
    logic [PW-1:0]   prod_sh;
    assign prod_sh   = prod_next >> Q;
    assign mag_final = prod_sh[N-2:0];
    assign ovf_final = |prod_sh[PW-1:N-1];
`endif

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.i_start) state_d = RUN;
            RUN:  if (count_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        count_d  = count_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE) begin
            if (bus.i_start) begin
                a_d     = {{(N-1){1'b0}}, bus.i_multiplicand[N-2:0]};
                b_d     = bus.i_multiplier[N-2:0];
                acc_d   = '0;
                sign_d  = bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1];
                count_d = CW'(N - 2);
                ovf_d   = 1'b0;
            end
        end else begin
            acc_d = prod_next;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            if (count_q == '0) begin
                // Sign is kept even for a zero magnitude (-0 is legal).
                result_d = {sign_q, mag_final};
                ovf_d    = ovf_final;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.o_complete   = (state_q == IDLE);
        bus.o_result_out = result_q;
        bus.o_overflow   = ovf_q;
    end
endmodule

// File: doc/qmult_seq.md
# qmult_seq

Sequential shift-and-add fixed-point multiplier in sign-magnitude (Q,N) format. It is the companion to the team's sequential fixed-point divider and uses the same number format, the same start/complete handshake and the same overflow semantics. This lets the pixel-scaling datapath alternate multiply and divide steps on one operand bus. It retires one multiplier bit per clock, trading latency for a single adder.

## Interface
- Q, 15, number of fractional bits; must satisfy 1 <= Q <= N-2
- N, 32, total word width including sign bit (bit N-1 = sign, bits N-2:0 = magnitude)
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_multiplicand  in  N  operand A, sign-magnitude Q-format
- i_multiplier  in  N  operand B, sign-magnitude Q-format
- i_start  in  1  request; sampled only while o_complete=1
- o_result_out  out  N  product; bit N-1 = sign, bits N-2:0 = magnitude
- o_complete  out  1  high = idle, result valid; low = busy
- o_overflow  out  1  product magnitude exceeded N-1 bits; valid while o_complete=1

## Operation
- States: IDLE (o_complete=1) and RUN (o_complete=0).
- Transition IDLE->RUN on a clock edge with i_start=1:
  - latch |A| into a (2N-2)-bit shift register;
  - latch |B| (N-1 bits) into a shift register;
  - clear the 2N-2-bit accumulator;
  - sign <= A[N-1] ^ B[N-1];
  - count <= N-2;
  - o_overflow <= 0.
- Each RUN cycle: if the B-register LSB is 1, the accumulator adds the A-register. Then the A-register shifts left 1, the B-register shifts right 1, and count decrements.
- RUN->IDLE on the edge where count==0. That edge:
  - includes the final partial product;
  - loads o_result_out;
  - sets o_complete=1.
- Result magnitude = P[N-2+Q:Q], where P is the full 2N-2-bit product (truncation toward zero, unless rounding is enabled).
- o_overflow = OR of P[2N-3:N-1+Q]. The magnitude is truncated, not saturated.
- Sign bit = XOR of the operand signs, even when the magnitude is 0. -0 is a legal output.
- i_start while busy is ignored. Operands are sampled only at acceptance and may change freely during RUN.
- o_result_out and o_overflow hold their values until the next completion. They do not clear at acceptance, except that o_overflow clears as stated above.

## Timing
- Reset (async assert, state independent):
  - o_complete=1, o_result_out=0, o_overflow=0;
  - all internal registers 0;
  - state IDLE.
- Reset deassertion is synchronized externally. The first accept is possible on the first edge after deassertion.
- Accept at edge T0: o_complete=0 from T0 through T0+N-2. At edge T0+N-1, o_result_out and o_overflow update and o_complete=1. Latency is N-1 cycles (31 at default).
- Back-to-back operation: i_start held high re-accepts on the edge following completion, so throughput is one result per N cycles.
- Reset during RUN aborts immediately with the reset values above. No partial result is ever presented.

## Configuration
- QMULT_ROUND_EN defined: round half up on the magnitude. Magnitude = P[N-2+Q:Q] + P[Q-1].
  - A carry out of bit N-2 sets o_overflow, and the magnitude wraps to the low N-1 bits.
  - Latency is unchanged; the rounding add is folded into the completion edge.
- Not defined: pure truncation; P[Q-1:0] is discarded.

## Test plan
- Reset, idle, defaults (Q=15, N=32): after reset, o_complete=1, o_result_out=0, o_overflow=0. Then A=0x0000C000 (1.5), B=0x00010000 (2.0), start pulse -> o_complete low for 31 cycles, then o_result_out=0x00018000 (3.0), o_overflow=0.
- Signed: A=0x8000C000 (-1.5), B=0x00010000 -> 0x80018000. A=0x80008000, B=0x80008000 (-1 * -1) -> 0x00008000. A=0x80000000, B=0x00008000 -> 0x80000000 (-0).
- Overflow: A=B=0x7FFFFFFF -> o_overflow=1, o_result_out[31]=0, magnitude equals P[45:15] truncated. A following 1.0*1.0 (0x00008000 * 0x00008000) -> 0x00008000 with o_overflow=0.
- Rounding: A=0x00000001, B=0x00004000 (LSB * 0.5) -> 0x00000001 with QMULT_ROUND_EN, 0x00000000 without.
- Busy start ignored: accept 1.5*2.0, then pulse i_start with different operands at cycle 10 -> result still 0x00018000 at cycle 31, and o_complete stays low throughout.
- Reset mid-operation: assert i_rst_n=0 at cycle 12 of RUN -> o_complete=1 and o_result_out=0 immediately. After release, a new 2.0*2.0 (0x00010000 * 0x00010000) -> 0x00020000 after 31 cycles.
